// File: rtl/ysyx_pkg.sv
// Shared types for the ysyx back end: renamed micro-op, operand bundle and
// issue-queue entry, plus the CDB wakeup helper used by every scheduler.
package ysyx_pkg;

    localparam int XLEN = 32;
    localparam int PLEN = 6;

    // Physical register 0 is hard-wired; it is never broadcast on the CDB.
    localparam logic [PLEN-1:0] RSV_TAG = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [7:0]      opcode;
    } uop_t;

    typedef struct packed {
        logic [PLEN-1:0] prd;
        logic [PLEN-1:0] pr1;
        logic [PLEN-1:0] pr2;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } prd_t;

    typedef struct packed {
        logic valid;
        logic rdy1;
        logic rdy2;
        uop_t uop;
        prd_t prd;
    } iq_entry_t;

    // Capture a CDB broadcast into any waiting operand of a valid entry.
    function automatic iq_entry_t iq_wake(input iq_entry_t e, input logic cv,
                                          input logic [PLEN-1:0] tag,
                                          input logic [XLEN-1:0] val);
        iq_entry_t r;
        r = e;
        if (cv && e.valid && tag != RSV_TAG) begin
            if (!e.rdy1 && e.prd.pr1 == tag) begin
                r.rdy1    = 1'b1;
                r.prd.op1 = val;
            end
            if (!e.rdy2 && e.prd.pr2 == tag) begin
                r.rdy2    = 1'b1;
                r.prd.op2 = val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_iq_if.sv
// Dispatch, CDB wakeup and issue signals between rename, the issue queue
// and execute. The queue is the slave; its environment is the master.
interface ysyx_iq_if;
    import ysyx_pkg::*;

    logic            disp_valid;
    logic            disp_ready;
    uop_t            disp_uop;
    prd_t            disp_prd;
    logic            disp_rdy1;
    logic            disp_rdy2;
    logic            cdb_valid;
    logic [PLEN-1:0] cdb_prd;
    logic [XLEN-1:0] cdb_value;
    logic            iss_valid;
    logic            iss_ready;
    uop_t            iss_uop;
    prd_t            iss_prd;

    modport master (
        output disp_valid, disp_uop, disp_prd, disp_rdy1, disp_rdy2,
        output cdb_valid, cdb_prd, cdb_value, iss_ready,
        input  disp_ready, iss_valid, iss_uop, iss_prd
    );

    modport slave (
        input  disp_valid, disp_uop, disp_prd, disp_rdy1, disp_rdy2,
        input  cdb_valid, cdb_prd, cdb_value, iss_ready,
        output disp_ready, iss_valid, iss_uop, iss_prd
    );

endinterface

// File: rtl/ysyx_iq_pick.sv
// Combinational priority encoder: lowest-index asserted request wins.
module ysyx_iq_pick #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downwards so the lowest asserted index is the last written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = SEL_W'(i);
        end
    end

endmodule

// File: rtl/ysyx_iq.sv
// Collapsing issue queue: entry 0 is the oldest, operands are captured from
// the CDB, and the oldest entry with both operands ready is offered to execute.
module ysyx_iq
    import ysyx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    ysyx_iq_if.slave io
);

    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_entry_t        entry_reg   [DEPTH];
    iq_entry_t        entry_next  [DEPTH];
    iq_entry_t        woke        [DEPTH];
    iq_entry_t        upper       [DEPTH];
    logic [IDX_W-1:0] count_reg;
    logic [IDX_W-1:0] count_next;
    logic [IDX_W-1:0] wr_idx;
    logic [DEPTH-1:0] ready_vec;
    logic [SEL_W-1:0] sel_idx;
    logic             found;
    logic             issue_fire;
    logic             disp_fire;
    iq_entry_t        new_raw;
    iq_entry_t        new_ent;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign woke[gi]      = iq_wake(entry_reg[gi], io.cdb_valid, io.cdb_prd, io.cdb_value);
            assign ready_vec[gi] = entry_reg[gi].valid && entry_reg[gi].rdy1 && entry_reg[gi].rdy2;
            // Source for each slot when an entry at or below it is issued.
            if (gi < DEPTH - 1) begin : g_up
                assign upper[gi] = woke[gi+1];
            end else begin : g_top
                assign upper[gi] = '0;
            end
        end
    endgenerate

    ysyx_iq_pick #(.N(DEPTH), .SEL_W(SEL_W)) u_pick (
        .req   (ready_vec),
        .found (found),
        .idx   (sel_idx)
    );

    // Readiness is judged on registered state only, so a wakeup this cycle
    // cannot make an entry issue until the next one.
    assign io.disp_ready = (count_reg != IDX_W'(DEPTH));
    assign io.iss_valid  = found && !flush;
    assign io.iss_uop    = entry_reg[sel_idx].uop;
    assign io.iss_prd    = entry_reg[sel_idx].prd;

    assign issue_fire = io.iss_valid && io.iss_ready;
    assign disp_fire  = io.disp_valid && io.disp_ready && !flush;
    assign wr_idx     = count_reg - IDX_W'(issue_fire);

    always_comb begin
        new_raw       = '0;
        new_raw.valid = 1'b1;
        new_raw.rdy1  = io.disp_rdy1;
        new_raw.rdy2  = io.disp_rdy2;
        new_raw.uop   = io.disp_uop;
        new_raw.prd   = io.disp_prd;
        // Same-cycle CDB bypass so a dispatch never misses a broadcast.
        new_ent       = iq_wake(new_raw, io.cdb_valid, io.cdb_prd, io.cdb_value);
    end

    always_comb begin
        count_next = count_reg;
        for (int i = 0; i < DEPTH; i++) begin
            entry_next[i] = woke[i];
            if (issue_fire && i >= int'(sel_idx)) entry_next[i] = upper[i];
        end
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(wr_idx)) entry_next[i] = new_ent;
            end
        end
        case ({disp_fire, issue_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) entry_next[i].valid = 1'b0;
            count_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
            count_reg <= count_next;
        end
    end

endmodule
